// File: rtl/inst_encoder_pkg.sv
// Shared RV32I opcode table, NOP word and instruction-format classification
// used by the encoder, its field packer and the bench.
package inst_encoder_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
    localparam logic [6:0] OPC_OP_IM  = 7'b001_0011;
    localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;
    localparam logic [6:0] OPC_STORE  = 7'b010_0011;
    localparam logic [6:0] OPC_OP     = 7'b011_0011;
    localparam logic [6:0] OPC_LUI    = 7'b011_0111;
    localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
    localparam logic [6:0] OPC_JALR   = 7'b110_0111;
    localparam logic [6:0] OPC_JAL    = 7'b110_1111;
    localparam logic [6:0] OPC_SYSTEM = 7'b111_0011;

    localparam logic [31:0] INST_NOP  = 32'h0000_0013;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_J   = 3'd4,
        FMT_U   = 3'd5,
        FMT_BAD = 3'd6
    } fmt_e;

    function automatic fmt_e opcode_fmt(input logic [6:0] opc);
        fmt_e f;
        case (opc)
            OPC_OP:                                     f = FMT_R;
            OPC_LOAD, OPC_OP_IM, OPC_JALR, OPC_SYSTEM:  f = FMT_I;
            OPC_STORE:                                  f = FMT_S;
            OPC_BRANCH:                                 f = FMT_B;
            OPC_JAL:                                    f = FMT_J;
            OPC_LUI, OPC_AUIPC:                         f = FMT_U;
            default:                                    f = FMT_BAD;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// Field-bundle input and {address, instruction} output handshakes of the encoder.
interface inst_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_addr;
    logic        out_err;

    modport slave (
        input  in_valid, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
        output in_ready, out_valid, out_inst, out_addr, out_err
    );

    modport master (
        output in_valid, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
        input  in_ready, out_valid, out_inst, out_addr, out_err
    );
endinterface

// File: rtl/inst_field_packer.sv
// Combinational RV32I field packer: places fields per format and flags
// immediates that do not fit, substituting a NOP for any rejected word.
module inst_field_packer
    import inst_encoder_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] inst,
    output logic        err
);

    fmt_e        fmt_s;
    logic        is_shift_s;
    logic [31:0] raw_s;
    logic        err_s;

    assign fmt_s      = opcode_fmt(opcode);
    assign is_shift_s = (opcode == OPC_OP_IM) && ((funct3 == 3'b001) || (funct3 == 3'b101));

    // Bit placement and immediate range check per instruction format
    always_comb begin
        raw_s = INST_NOP;
        err_s = 1'b1;
        case (fmt_s)
            FMT_R: begin
                raw_s = {funct7, rs2, rs1, funct3, rd, opcode};
                err_s = 1'b0;
            end
            FMT_I: begin
                if (is_shift_s) begin
                    raw_s = {funct7, imm[4:0], rs1, funct3, rd, opcode};
                    err_s = (imm[31:5] != {27{1'b0}});
                end else begin
                    raw_s = {imm[11:0], rs1, funct3, rd, opcode};
                    err_s = !((imm[31:11] == {21{1'b0}}) || (imm[31:11] == {21{1'b1}}));
                end
            end
            FMT_S: begin
                raw_s = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                err_s = !((imm[31:11] == {21{1'b0}}) || (imm[31:11] == {21{1'b1}}));
            end
            FMT_B: begin
                raw_s = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                err_s = imm[0] || !((imm[31:12] == {20{1'b0}}) || (imm[31:12] == {20{1'b1}}));
            end
            FMT_J: begin
                raw_s = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                err_s = imm[0] || !((imm[31:20] == {12{1'b0}}) || (imm[31:20] == {12{1'b1}}));
            end
            FMT_U: begin
                raw_s = {imm[31:12], rd, opcode};
                err_s = (imm[11:0] != 12'h000);
            end
            default: begin
                raw_s = INST_NOP;
                err_s = 1'b1;
            end
        endcase
    end

    assign inst = err_s ? INST_NOP : raw_s;
    assign err  = err_s;

endmodule

// File: rtl/inst_encoder.sv
// RV32I instruction encoder: one registered stage that turns field bundles
// into {address, instruction} pairs and counts rejected words.
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          ERRW      = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            restart,
    inst_encoder_if.slave   bus,
    output logic [ERRW-1:0] err_count
);

    logic [31:0]     pack_inst_s;
    logic            pack_err_s;
    logic            in_ready_s;
    logic            accept_s;
    logic            fire_s;

    logic            out_valid_q, out_valid_d;
    logic [31:0]     out_inst_q,  out_inst_d;
    logic [31:0]     out_addr_q,  out_addr_d;
    logic            out_err_q,   out_err_d;
    logic [ERRW-1:0] err_count_q, err_count_d;

    inst_field_packer u_packer (
        .opcode (bus.opcode),
        .rd     (bus.rd),
        .rs1    (bus.rs1),
        .rs2    (bus.rs2),
        .funct3 (bus.funct3),
        .funct7 (bus.funct7),
        .imm    (bus.imm),
        .inst   (pack_inst_s),
        .err    (pack_err_s)
    );

    // A restart discards the held word, so it must not count as taken
    assign in_ready_s = !reset && !restart && (!out_valid_q || bus.out_ready);
    assign accept_s   = bus.in_valid && in_ready_s;
    assign fire_s     = out_valid_q && bus.out_ready && !restart;

    // Output register, address counter and saturating error counter
    always_comb begin
        out_valid_d = out_valid_q;
        out_inst_d  = out_inst_q;
        out_addr_d  = out_addr_q;
        out_err_d   = out_err_q;
        err_count_d = err_count_q;
        if (restart) begin
            out_valid_d = 1'b0;
            out_addr_d  = BASE_ADDR;
        end else begin
            if (fire_s) begin
                out_addr_d = out_addr_q + 32'd4;
            end else begin
                out_addr_d = out_addr_q;
            end
            if (accept_s) begin
                out_valid_d = 1'b1;
                out_inst_d  = pack_inst_s;
                out_err_d   = pack_err_s;
            end else if (fire_s) begin
                out_valid_d = 1'b0;
            end else begin
                out_valid_d = out_valid_q;
            end
            if (fire_s && out_err_q && (err_count_q != {ERRW{1'b1}})) begin
                err_count_d = err_count_q + {{(ERRW-1){1'b0}}, 1'b1};
            end else begin
                err_count_d = err_count_q;
            end
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_inst_q  <= 32'h0000_0000;
            out_addr_q  <= BASE_ADDR;
            out_err_q   <= 1'b0;
            err_count_q <= {ERRW{1'b0}};
        end else begin
            out_valid_q <= out_valid_d;
            out_inst_q  <= out_inst_d;
            out_addr_q  <= out_addr_d;
            out_err_q   <= out_err_d;
            err_count_q <= err_count_d;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_q;
    assign bus.out_inst  = out_inst_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.out_err   = out_err_q;
    assign err_count     = err_count_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: expected words are queued on accept
// and compared when the encoder hands them out.
module tb_inst_encoder;
    import inst_encoder_pkg::*;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        restart;
    logic [15:0] err_count;

    exp_t        sb[$];
    logic [31:0] exp_addr;
    int          tests_run;
    int          tests_failed;

    inst_encoder_if bus();

    inst_encoder #(.BASE_ADDR(32'h0000_0000), .ERRW(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .restart   (restart),
        .bus       (bus),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    // One clock; any word handed out this cycle is checked against the queue head
    task automatic step(output logic acc);
        exp_t e;
        @(negedge clk);
        if (bus.out_valid && bus.out_ready && !restart && !reset) begin
            tests_run++;
            if (sb.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_word: got inst %h addr %h, queue empty", bus.out_inst, bus.out_addr);
            end else begin
                e = sb.pop_front();
                if ({bus.out_inst, bus.out_addr, bus.out_err} !== {e.inst, e.addr, e.err}) begin
                    tests_failed++;
                    $display("FAIL word: got inst %h addr %h err %b, expected inst %h addr %h err %b",
                             bus.out_inst, bus.out_addr, bus.out_err, e.inst, e.addr, e.err);
                end
            end
        end
        acc = bus.in_valid && bus.in_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] imm);
        bus.opcode   = op;
        bus.rd       = rd;
        bus.rs1      = rs1;
        bus.rs2      = rs2;
        bus.funct3   = f3;
        bus.funct7   = f7;
        bus.imm      = imm;
        bus.in_valid = 1'b1;
    endtask

    task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm, input logic [31:0] exp_inst, input logic exp_err);
        logic acc;
        int   n;
        exp_t e;
        drive(op, rd, rs1, rs2, f3, f7, imm);
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 20) begin
            step(acc);
            n++;
        end
        tests_run++;
        if (!acc) begin
            tests_failed++;
            $display("FAIL send_timeout: got no accept, expected accept within 20 cycles (inst %h)", exp_inst);
        end else begin
            e.inst = exp_inst;
            e.addr = exp_addr;
            e.err  = exp_err;
            sb.push_back(e);
            exp_addr = exp_addr + 32'd4;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        logic acc;
        int   n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            step(acc);
            n++;
        end
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL drain: got %0d words outstanding, expected 0", sb.size());
        end
    endtask

    task automatic do_reset();
        logic acc;
        reset = 1'b1;
        step(acc);
        step(acc);
        reset = 1'b0;
        sb.delete();
        exp_addr = 32'h0000_0000;
    endtask

    task automatic test_reset();
        logic acc;
        reset = 1'b1;
        step(acc);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        #1;
        tests_run++;
        if (bus.in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready);
        end
        step(acc);
        bus.in_valid = 1'b0;
        reset = 1'b0;
        tests_run++;
        if ({bus.out_valid, bus.out_inst, bus.out_err, bus.out_addr, err_count} !==
            {1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 16'h0000}) begin
            tests_failed++;
            $display("FAIL reset_state: got valid %b inst %h err %b addr %h cnt %h, expected all zero",
                     bus.out_valid, bus.out_inst, bus.out_err, bus.out_addr, err_count);
        end
        sb.delete();
        exp_addr = 32'h0000_0000;
    endtask

    task automatic test_formats();
        bus.out_ready = 1'b1;
        send(OPC_OP_IM,  5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd5,         32'h0050_0093, 1'b0);
        send(OPC_JAL,    5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd8,         32'h0080_00EF, 1'b0);
        send(OPC_BRANCH, 5'd0, 5'd1, 5'd2, 3'b000, 7'h00, 32'hFFFF_FFFC, 32'hFE20_8EE3, 1'b0);
        send(OPC_STORE,  5'd0, 5'd1, 5'd2, 3'b010, 7'h00, 32'd8,         32'h0020_A423, 1'b0);
        send(OPC_LUI,    5'd5, 5'd0, 5'd0, 3'b000, 7'h00, 32'h1234_5000, 32'h1234_52B7, 1'b0);
        send(OPC_OP_IM,  5'd1, 5'd1, 5'd0, 3'b001, 7'h00, 32'd3,         32'h0030_9093, 1'b0);
        send(OPC_OP_IM,  5'd1, 5'd1, 5'd0, 3'b101, 7'h20, 32'd3,         32'h4030_D093, 1'b0);
        send(OPC_OP,     5'd3, 5'd1, 5'd2, 3'b000, 7'h00, 32'hDEAD_BEEF, 32'h0020_81B3, 1'b0);
        send(OPC_OP_IM,  5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'hFFFF_F800, 32'h8000_0093, 1'b0);
        drain();
    endtask

    task automatic test_back_to_back();
        logic acc;
        do_reset();
        bus.out_ready = 1'b1;
        send(OPC_OP_IM, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd1, 32'h0010_0093, 1'b0);
        send(OPC_OP_IM, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd2, 32'h0020_0093, 1'b0);
        send(OPC_OP_IM, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd3, 32'h0030_0093, 1'b0);
        bus.out_ready = 1'b0;
        drive(OPC_OP_IM, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd4);
        for (int i = 0; i < 3; i++) begin
            step(acc);
            tests_run++;
            if ({acc, bus.in_ready, bus.out_valid, bus.out_inst, bus.out_addr} !==
                {1'b0, 1'b0, 1'b1, 32'h0030_0093, 32'h0000_0008}) begin
                tests_failed++;
                $display("FAIL stall_hold: got acc %b in_ready %b valid %b inst %h addr %h, expected 0 0 1 00300093 00000008",
                         acc, bus.in_ready, bus.out_valid, bus.out_inst, bus.out_addr);
            end
        end
        bus.out_ready = 1'b1;
        send(OPC_OP_IM, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd4, 32'h0040_0093, 1'b0);
        tests_run++;
        if (bus.out_addr !== 32'h0000_000C) begin
            tests_failed++;
            $display("FAIL fourth_addr: got %h expected 0000000c", bus.out_addr);
        end
        drain();
    endtask

    task automatic check_cnt(input string name, input logic [15:0] exp_cnt);
        tests_run++;
        if (err_count !== exp_cnt) begin
            tests_failed++;
            $display("FAIL %s: got err_count %0d expected %0d", name, err_count, exp_cnt);
        end
    endtask

    task automatic test_errors();
        do_reset();
        bus.out_ready = 1'b1;
        send(OPC_LUI,    5'd5, 5'd0, 5'd0, 3'b000, 7'h00, 32'h1234_5001, INST_NOP, 1'b1);
        drain();
        check_cnt("err_lui", 16'd1);
        send(OPC_OP_IM,  5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd2048, INST_NOP, 1'b1);
        drain();
        check_cnt("err_addi", 16'd2);
        send(OPC_BRANCH, 5'd0, 5'd1, 5'd2, 3'b000, 7'h00, 32'd3, INST_NOP, 1'b1);
        drain();
        check_cnt("err_branch", 16'd3);
        send(OPC_OP_IM,  5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'hFFFF_F800, 32'h8000_0093, 1'b0);
        drain();
        check_cnt("no_err_min_imm", 16'd3);
        send(7'b000_0000, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd0, INST_NOP, 1'b1);
        drain();
        check_cnt("err_opcode", 16'd4);
        send(OPC_OP_IM,  5'd1, 5'd1, 5'd0, 3'b001, 7'h00, 32'd32, INST_NOP, 1'b1);
        drain();
        check_cnt("err_shamt", 16'd5);
    endtask

    task automatic test_restart();
        logic acc;
        bus.out_ready = 1'b0;
        send(OPC_OP_IM, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd7, 32'h0070_0093, 1'b0);
        restart       = 1'b1;
        bus.out_ready = 1'b1;
        drive(OPC_OP_IM, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd9);
        #1;
        tests_run++;
        if (bus.in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL restart_in_ready: got %b expected 0", bus.in_ready);
        end
        step(acc);
        restart = 1'b0;
        void'(sb.pop_back());
        exp_addr = 32'h0000_0000;
        tests_run++;
        if ({bus.out_valid, bus.out_addr, err_count} !== {1'b0, 32'h0000_0000, 16'd5}) begin
            tests_failed++;
            $display("FAIL restart_state: got valid %b addr %h cnt %0d, expected 0 00000000 5",
                     bus.out_valid, bus.out_addr, err_count);
        end
        send(OPC_OP_IM, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd9, 32'h0090_0093, 1'b0);
        drain();
        check_cnt("restart_cnt_kept", 16'd5);
    endtask

    task automatic test_reset_clears();
        logic acc;
        bus.out_ready = 1'b0;
        send(OPC_LUI, 5'd5, 5'd0, 5'd0, 3'b000, 7'h00, 32'h0000_0001, INST_NOP, 1'b1);
        reset = 1'b1;
        step(acc);
        step(acc);
        reset = 1'b0;
        sb.delete();
        exp_addr = 32'h0000_0000;
        tests_run++;
        if ({bus.out_valid, bus.out_addr, err_count} !== {1'b0, 32'h0000_0000, 16'd0}) begin
            tests_failed++;
            $display("FAIL reset_clears: got valid %b addr %h cnt %0d, expected 0 00000000 0",
                     bus.out_valid, bus.out_addr, err_count);
        end
    endtask

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        exp_addr      = 32'h0000_0000;
        reset         = 1'b1;
        restart       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.opcode    = 7'h00;
        bus.rd        = 5'd0;
        bus.rs1       = 5'd0;
        bus.rs2       = 5'd0;
        bus.funct3    = 3'b000;
        bus.funct7    = 7'h00;
        bus.imm       = 32'h0000_0000;
        @(posedge clk);
        #1;
        test_reset();
        test_formats();
        test_back_to_back();
        test_errors();
        test_restart();
        test_reset_clears();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
